dmem_axil_bridge: RTL and testbench
===================================

// Module: dmem_axil_bridge
// PURPOSE
// - AXI4-Lite slave that gives the RV32I core's data port (HOST_AXI_*) access to data memory.
// - Test mode (RISCOF_TEST_MODE=1):
//   - Memory lives outside the block.
//   - Read data arrives combinationally on DMEM_RDATA.
//   - The block drives DMEM_WDATA, the strobe-merged write word.
//   - The word currently at the write address arrives on DMEM_WDATA_READ.
//   - The environment commits a write in the cycle AWVALID&AWREADY&WVALID is high.
// - Normal mode (RISCOF_TEST_MODE=0): the block holds an internal word array.
// PARAMETERS
// RISCOF_TEST_MODE  1      1=external memory via DMEM_* ports, 0=internal array
// INT_DMEM_SIZE     1024   internal array depth in 32-bit words (ignored when RISCOF_TEST_MODE=1)
// AXI_AWIDTH        32     address width; the full 32 bits are carried, e.g. 0xF0000004
// AXI_DWIDTH        32     data width; WSTRB width is AXI_DWIDTH/8
// PORTS
// sysclk           in   1       clock, all logic on rising edge
// NRST             in   1       reset, synchronous, active-low
// AXI_AWADDR       in   AWIDTH  write address (byte)
// AXI_AWVALID      in   1       write address valid
// AXI_AWREADY      out  1       write address accepted
// AXI_WDATA        in   DWIDTH  write data
// AXI_WSTRB        in   4       byte enables, bit i -> WDATA[8i+7:8i]
// AXI_WVALID       in   1       write data valid
// AXI_WREADY       out  1       write data accepted
// AXI_BRESP        out  2       write response, always 2'b00 OKAY
// AXI_BVALID       out  1       write response valid
// AXI_BREADY       in   1       master ready for response
// AXI_ARADDR       in   AWIDTH  read address (byte)
// AXI_ARVALID      in   1       read address valid
// AXI_ARREADY      out  1       read address accepted
// AXI_RDATA        out  DWIDTH  read data (registered)
// AXI_RRESP        out  2       read response, always 2'b00
// AXI_RVALID       out  1       read data valid
// AXI_RREADY       in   1       master ready for read data
// DMEM_RDATA       in   32      external word at ARADDR (test mode)
// DMEM_WDATA       out  32      strobe-merged word to store (combinational)
// DMEM_WDATA_READ  in   32      external word currently at AWADDR (test mode)
// BEHAVIOUR
// - Reset (NRST=0 at clock edge):
//   - Both FSMs go to IDLE.
//   - AWREADY=WREADY=BVALID=ARREADY=RVALID=0, RDATA=0, BRESP=RRESP=0.
//   - Internal array contents are not cleared.
//   - Reset mid-transaction abandons it; no pending response survives.
// - Write FSM, states W_IDLE and W_RESP:
//   - AWREADY=WREADY=1 (combinational) only when in W_IDLE and AWVALID and WVALID are both 1.
//   - An address without data, or data without address, waits; neither is accepted alone.
//   - On that handshake cycle the write commits:
//     - internal mode writes the array at the edge;
//     - test mode relies on the environment sampling DMEM_WDATA.
//   - The FSM then moves to W_RESP.
//   - W_RESP: BVALID=1 and BRESP=00, held until BREADY=1, then back to W_IDLE.
//   - If BREADY is already high, BVALID lasts exactly 1 cycle.
//   - No new write is accepted while in W_RESP.
// - DMEM_WDATA, per byte i: WSTRB[i] ? WDATA[8i+7:8i] : OLD[8i+7:8i].
//   - OLD is DMEM_WDATA_READ in test mode.
//   - OLD is array[AWADDR[..:2]] in internal mode.
// - Read FSM, states R_IDLE and R_DATA:
//   - ARREADY=1 (combinational) when in R_IDLE and ARVALID=1.
//   - On the handshake, RDATA is registered, then the FSM moves to R_DATA:
//     - from DMEM_RDATA in test mode;
//     - from array[ARADDR[..:2]] in internal mode.
//   - R_DATA: RVALID=1 and RDATA held stable until RREADY=1, then back to R_IDLE.
//   - Read latency is 1 cycle from the AR handshake to RVALID.
// - The read and write FSMs are independent; a read and a write may handshake in the same cycle.
//   - A same-address read in that cycle returns the old data.
// - Internal index wraps modulo INT_DMEM_SIZE (low address bits only); no error response is ever generated.
// - No address decoding is done here; special addresses (0xF0000000/4) are handled by the environment.
// TESTING
// - Reset: hold NRST=0 for 2 cycles -> all ready/valid outputs are 0 and RDATA=0.
// - Full write: AW=0x10, W=0xDEADBEEF, STRB=0xF, BREADY=1 -> AWREADY=WREADY=1 in the same cycle, DMEM_WDATA=0xDEADBEEF, BVALID for exactly 1 cycle, BRESP=0.
// - Byte write: DMEM_WDATA_READ=0x11223344, WDATA=0x000000AA, STRB=0x1 -> DMEM_WDATA=0x112233AA; with STRB=0xC and WDATA=0x55660000 -> 0x55663344.
// - Read: ARADDR=0x10, DMEM_RDATA=0xCAFECAFE, RREADY held 0 for 3 cycles -> RVALID=1 one cycle after ARREADY, RDATA=0xCAFECAFE stable until RREADY=1.
// - Split channels: AWVALID=1 with WVALID=0 for 4 cycles -> AWREADY stays 0 and no write; raising WVALID -> handshake in that cycle.
// - Backpressure: BREADY=0 for 5 cycles after a write -> BVALID held and a second AW/W pair is not accepted until B completes.

Source files
------------

// File: rtl/dmem_axil_bridge_if.sv
// AXI4-Lite bus bundle between the core's data port (master) and the dmem bridge (slave).
interface dmem_axil_bridge_if #(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0]   AXI_AWADDR;
  logic                    AXI_AWVALID;
  logic                    AXI_AWREADY;
  logic [AXI_DWIDTH-1:0]   AXI_WDATA;
  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB;
  logic                    AXI_WVALID;
  logic                    AXI_WREADY;
  logic [1:0]              AXI_BRESP;
  logic                    AXI_BVALID;
  logic                    AXI_BREADY;
  logic [AXI_AWIDTH-1:0]   AXI_ARADDR;
  logic                    AXI_ARVALID;
  logic                    AXI_ARREADY;
  logic [AXI_DWIDTH-1:0]   AXI_RDATA;
  logic [1:0]              AXI_RRESP;
  logic                    AXI_RVALID;
  logic                    AXI_RREADY;

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
           AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID, AXI_ARREADY, AXI_RDATA,
           AXI_RRESP, AXI_RVALID
  );

  modport master (
    output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
           AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID, AXI_ARREADY, AXI_RDATA,
           AXI_RRESP, AXI_RVALID
  );
endinterface

// File: rtl/dmem_axil_bridge.sv
// AXI4-Lite slave giving the RV32I data port access to data memory, either an external
// memory (test mode) or an internal word array.
module dmem_axil_bridge #(
  parameter int unsigned RISCOF_TEST_MODE = 1,
  parameter int unsigned INT_DMEM_SIZE    = 1024,
  parameter int unsigned AXI_AWIDTH       = 32,
  parameter int unsigned AXI_DWIDTH       = 32
) (
  input  logic                  sysclk,
  input  logic                  NRST,
  dmem_axil_bridge_if.slave     axi,
  input  logic [AXI_DWIDTH-1:0] DMEM_RDATA,
  output logic [AXI_DWIDTH-1:0] DMEM_WDATA,
  input  logic [AXI_DWIDTH-1:0] DMEM_WDATA_READ
);
  localparam int unsigned StrbW = AXI_DWIDTH / 8;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic [AXI_DWIDTH-1:0] w_old;
  logic [AXI_DWIDTH-1:0] w_rd_src;
  logic [AXI_DWIDTH-1:0] r_rdata;

  // Write FSM: address and data are only ever accepted together.
  always_comb begin
    w_wstate_nxt    = r_wstate;
    w_wr_hs         = 1'b0;
    axi.AXI_BVALID  = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        w_wr_hs = axi.AXI_AWVALID & axi.AXI_WVALID;
        if (w_wr_hs) w_wstate_nxt = WResp;
      end
      WResp: begin
        axi.AXI_BVALID = 1'b1;
        if (axi.AXI_BREADY) w_wstate_nxt = WIdle;
      end
      default: w_wstate_nxt = WIdle;
    endcase
  end

  assign axi.AXI_AWREADY = w_wr_hs;
  assign axi.AXI_WREADY  = w_wr_hs;
  assign axi.AXI_BRESP   = 2'b00;

  always_ff @(posedge sysclk) begin
    if (!NRST) r_wstate <= WIdle;
    else       r_wstate <= w_wstate_nxt;
  end

  // Read FSM: one cycle from AR handshake to RVALID, data held until RREADY.
  always_comb begin
    w_rstate_nxt   = r_rstate;
    w_rd_hs        = 1'b0;
    axi.AXI_RVALID = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        w_rd_hs = axi.AXI_ARVALID;
        if (w_rd_hs) w_rstate_nxt = RData;
      end
      RData: begin
        axi.AXI_RVALID = 1'b1;
        if (axi.AXI_RREADY) w_rstate_nxt = RIdle;
      end
      default: w_rstate_nxt = RIdle;
    endcase
  end

  assign axi.AXI_ARREADY = w_rd_hs;
  assign axi.AXI_RRESP   = 2'b00;
  assign axi.AXI_RDATA   = r_rdata;

  always_ff @(posedge sysclk) begin
    if (!NRST) begin
      r_rstate <= RIdle;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_rd_hs) r_rdata <= w_rd_src;
    end
  end

  // Strobe merge onto the word currently stored at the write address.
  always_comb begin
    DMEM_WDATA = w_old;
    for (int i = 0; i < StrbW; i++) begin
      if (axi.AXI_WSTRB[i]) DMEM_WDATA[8*i +: 8] = axi.AXI_WDATA[8*i +: 8];
    end
  end

  if (RISCOF_TEST_MODE != 0) begin : g_ext
    logic w_unused_ext;
    assign w_old        = DMEM_WDATA_READ;
    assign w_rd_src     = DMEM_RDATA;
    assign w_unused_ext = ^{axi.AXI_AWADDR, axi.AXI_ARADDR};
  end else begin : g_int
    // Index uses low word-address bits only, so depth is expected to be a power of two.
    localparam int unsigned IdxW = (INT_DMEM_SIZE > 1) ? $clog2(INT_DMEM_SIZE) : 1;

    logic [AXI_DWIDTH-1:0] r_mem [INT_DMEM_SIZE];
    logic [IdxW-1:0]       w_widx;
    logic [IdxW-1:0]       w_ridx;
    logic                  w_unused_int;

    assign w_widx       = axi.AXI_AWADDR[IdxW+1:2];
    assign w_ridx       = axi.AXI_ARADDR[IdxW+1:2];
    assign w_old        = r_mem[w_widx];
    assign w_rd_src     = r_mem[w_ridx];
    assign w_unused_int = ^{DMEM_RDATA, DMEM_WDATA_READ, axi.AXI_AWADDR, axi.AXI_ARADDR};

    // Contents survive reset; a same-edge read sees the pre-write word.
    always_ff @(posedge sysclk) begin
      if (w_wr_hs) r_mem[w_widx] <= DMEM_WDATA;
    end
  end
endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Directed self-checking bench for dmem_axil_bridge in external-memory (test) mode.
module tb_dmem_axil_bridge;
  logic        sysclk = 1'b0;
  logic        NRST;
  logic [31:0] DMEM_RDATA;
  logic [31:0] DMEM_WDATA;
  logic [31:0] DMEM_WDATA_READ;

  int tests  = 0;
  int failed = 0;

  dmem_axil_bridge_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) bus ();

  dmem_axil_bridge #(
    .RISCOF_TEST_MODE(1),
    .INT_DMEM_SIZE   (1024),
    .AXI_AWIDTH      (32),
    .AXI_DWIDTH      (32)
  ) dut (
    .sysclk         (sysclk),
    .NRST           (NRST),
    .axi            (bus.slave),
    .DMEM_RDATA     (DMEM_RDATA),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_WDATA_READ(DMEM_WDATA_READ)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    NRST                = 1'b0;
    bus.AXI_AWADDR      = '0;
    bus.AXI_AWVALID     = 1'b0;
    bus.AXI_WDATA       = '0;
    bus.AXI_WSTRB       = '0;
    bus.AXI_WVALID      = 1'b0;
    bus.AXI_BREADY      = 1'b0;
    bus.AXI_ARADDR      = '0;
    bus.AXI_ARVALID     = 1'b0;
    bus.AXI_RREADY      = 1'b0;
    DMEM_RDATA          = '0;
    DMEM_WDATA_READ     = '0;

    // Reset
    step();
    step();
    chk("rst_awready", {31'd0, bus.AXI_AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, bus.AXI_WREADY},  32'd0);
    chk("rst_bvalid",  {31'd0, bus.AXI_BVALID},  32'd0);
    chk("rst_arready", {31'd0, bus.AXI_ARREADY}, 32'd0);
    chk("rst_rvalid",  {31'd0, bus.AXI_RVALID},  32'd0);
    chk("rst_rdata",   bus.AXI_RDATA,            32'd0);
    chk("rst_resp",    {28'd0, bus.AXI_BRESP, bus.AXI_RRESP}, 32'd0);
    NRST = 1'b1;
    step();

    // Full-word write with BREADY already high
    bus.AXI_AWADDR  = 32'h10;
    bus.AXI_WDATA   = 32'hDEADBEEF;
    bus.AXI_WSTRB   = 4'hF;
    bus.AXI_AWVALID = 1'b1;
    bus.AXI_WVALID  = 1'b1;
    bus.AXI_BREADY  = 1'b1;
    #1;
    chk("full_awready", {31'd0, bus.AXI_AWREADY}, 32'd1);
    chk("full_wready",  {31'd0, bus.AXI_WREADY},  32'd1);
    chk("full_wdata",   DMEM_WDATA,               32'hDEADBEEF);
    chk("full_bv_pre",  {31'd0, bus.AXI_BVALID},  32'd0);
    step();
    bus.AXI_AWVALID = 1'b0;
    bus.AXI_WVALID  = 1'b0;
    #1;
    chk("full_bvalid",  {31'd0, bus.AXI_BVALID},  32'd1);
    chk("full_bresp",   {30'd0, bus.AXI_BRESP},   32'd0);
    step();
    chk("full_bv_end",  {31'd0, bus.AXI_BVALID},  32'd0);

    // Byte-strobe merge against the externally supplied old word
    DMEM_WDATA_READ = 32'h11223344;
    bus.AXI_WDATA   = 32'h000000AA;
    bus.AXI_WSTRB   = 4'h1;
    #1;
    chk("merge_b0", DMEM_WDATA, 32'h112233AA);
    bus.AXI_WDATA = 32'h55660000;
    bus.AXI_WSTRB = 4'hC;
    #1;
    chk("merge_hi", DMEM_WDATA, 32'h55663344);
    bus.AXI_WSTRB = 4'h0;
    #1;
    chk("merge_none", DMEM_WDATA, 32'h11223344);
    step();

    // Read with RREADY held low for three RVALID cycles
    bus.AXI_ARADDR  = 32'h10;
    bus.AXI_ARVALID = 1'b1;
    DMEM_RDATA      = 32'hCAFECAFE;
    #1;
    chk("rd_arready", {31'd0, bus.AXI_ARREADY}, 32'd1);
    chk("rd_rv_pre",  {31'd0, bus.AXI_RVALID},  32'd0);
    step();
    DMEM_RDATA = 32'h0BADF00D;
    #1;
    chk("rd_rvalid", {31'd0, bus.AXI_RVALID},  32'd1);
    chk("rd_rdata",  bus.AXI_RDATA,            32'hCAFECAFE);
    chk("rd_ar_busy", {31'd0, bus.AXI_ARREADY}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rd_hold_rv", {31'd0, bus.AXI_RVALID}, 32'd1);
      chk("rd_hold_d",  bus.AXI_RDATA,           32'hCAFECAFE);
    end
    bus.AXI_ARVALID = 1'b0;
    bus.AXI_RREADY  = 1'b1;
    step();
    bus.AXI_RREADY = 1'b0;
    #1;
    chk("rd_rv_end", {31'd0, bus.AXI_RVALID}, 32'd0);
    chk("rd_d_keep", bus.AXI_RDATA,           32'hCAFECAFE);

    // Address without data is not accepted
    bus.AXI_AWADDR  = 32'h20;
    bus.AXI_WDATA   = 32'h12345678;
    bus.AXI_WSTRB   = 4'hF;
    bus.AXI_AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("split_awready", {31'd0, bus.AXI_AWREADY}, 32'd0);
      chk("split_bvalid",  {31'd0, bus.AXI_BVALID},  32'd0);
      step();
    end
    bus.AXI_WVALID = 1'b1;
    #1;
    chk("split_hs", {30'd0, bus.AXI_AWREADY, bus.AXI_WREADY}, 32'd3);
    step();
    bus.AXI_AWVALID = 1'b0;
    bus.AXI_WVALID  = 1'b0;
    #1;
    chk("split_bvalid1", {31'd0, bus.AXI_BVALID}, 32'd1);
    step();

    // Data without address is not accepted either
    bus.AXI_WVALID = 1'b1;
    #1;
    chk("wonly_wready", {31'd0, bus.AXI_WREADY}, 32'd0);
    bus.AXI_WVALID = 1'b0;
    step();

    // B backpressure blocks a second write
    bus.AXI_BREADY  = 1'b0;
    bus.AXI_AWADDR  = 32'h30;
    bus.AXI_AWVALID = 1'b1;
    bus.AXI_WVALID  = 1'b1;
    #1;
    chk("bp_hs1", {31'd0, bus.AXI_AWREADY}, 32'd1);
    step();
    bus.AXI_AWADDR = 32'h34;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bvalid",  {31'd0, bus.AXI_BVALID},  32'd1);
      chk("bp_blocked", {30'd0, bus.AXI_AWREADY, bus.AXI_WREADY}, 32'd0);
      step();
    end
    bus.AXI_BREADY = 1'b1;
    #1;
    chk("bp_still", {31'd0, bus.AXI_AWREADY}, 32'd0);
    step();
    chk("bp_hs2",    {31'd0, bus.AXI_AWREADY}, 32'd1);
    chk("bp_bv_gap", {31'd0, bus.AXI_BVALID},  32'd0);
    step();
    bus.AXI_AWVALID = 1'b0;
    bus.AXI_WVALID  = 1'b0;
    #1;
    chk("bp_bvalid2", {31'd0, bus.AXI_BVALID}, 32'd1);
    step();

    // Simultaneous read and write handshakes
    bus.AXI_AWVALID = 1'b1;
    bus.AXI_WVALID  = 1'b1;
    bus.AXI_ARVALID = 1'b1;
    bus.AXI_ARADDR  = 32'h30;
    DMEM_RDATA      = 32'hA5A55A5A;
    #1;
    chk("dual_hs", {30'd0, bus.AXI_AWREADY, bus.AXI_ARREADY}, 32'd3);
    step();
    bus.AXI_AWVALID = 1'b0;
    bus.AXI_WVALID  = 1'b0;
    bus.AXI_ARVALID = 1'b0;
    bus.AXI_RREADY  = 1'b1;
    #1;
    chk("dual_valids", {30'd0, bus.AXI_BVALID, bus.AXI_RVALID}, 32'd3);
    chk("dual_rdata",  bus.AXI_RDATA, 32'hA5A55A5A);
    step();
    bus.AXI_RREADY = 1'b0;

    // Reset abandons a pending response
    bus.AXI_BREADY  = 1'b0;
    bus.AXI_AWVALID = 1'b1;
    bus.AXI_WVALID  = 1'b1;
    bus.AXI_ARVALID = 1'b1;
    step();
    bus.AXI_AWVALID = 1'b0;
    bus.AXI_WVALID  = 1'b0;
    bus.AXI_ARVALID = 1'b0;
    #1;
    chk("mid_pending", {30'd0, bus.AXI_BVALID, bus.AXI_RVALID}, 32'd3);
    NRST = 1'b0;
    step();
    chk("mid_rst_valids", {30'd0, bus.AXI_BVALID, bus.AXI_RVALID}, 32'd0);
    chk("mid_rst_rdata",  bus.AXI_RDATA, 32'd0);
    NRST = 1'b1;
    step();
    chk("mid_after", {30'd0, bus.AXI_BVALID, bus.AXI_RVALID}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
